noc2validready_handshake_adapter: RTL

- Egress counterpart of validready2noc_handshake_adapter.
- Sits at a NoC ejection port and consumes flits that the router delivers under credit-based flow control.
- Buffers flits per virtual channel (VC), returns one credit per freed slot, and presents flits to the local consumer over a standard valid/ready handshake with a VC id.
- A round-robin arbiter shares the single valid/ready output among non-empty VCs.

---
 rtl/noc2validready_handshake_adapter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/noc2validready_handshake_adapter.sv
// NoC ejection adapter: per-VC flit buffers fed under credit flow control,
// drained round-robin onto a single valid/ready consumer port with a VC id.
module noc2validready_handshake_adapter #(
  parameter int VirtualChannelIdWidth = 1,
  parameter int FlitWidth             = 32,
  parameter int BufferDepth           = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  noc_flit_valid_i,
  input  logic [FlitWidth-1:0]                  noc_flit_i,
  input  logic [VirtualChannelIdWidth-1:0]      noc_virtual_channel_id_i,
  output logic [(1<<VirtualChannelIdWidth)-1:0] noc_credit_o,
  output logic                                  valid,
  input  logic                                  ready,
  output logic [FlitWidth-1:0]                  data,
  output logic [VirtualChannelIdWidth-1:0]      virtual_channel_id,
  output logic                                  overflow_o,
  output logic                                  dbg_state
);

  localparam int VcW   = VirtualChannelIdWidth;
  localparam int NumVc = 1 << VcW;
  localparam int PtrW  = $clog2(BufferDepth);
  localparam int CntW  = PtrW + 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [FlitWidth-1:0] mem      [NumVc][BufferDepth];
  logic [PtrW-1:0]      wr_ptr_q [NumVc];
  logic [PtrW-1:0]      rd_ptr_q [NumVc];
  logic [CntW-1:0]      count_q  [NumVc];

  logic [0:0]       state_q;
  logic [VcW-1:0]   grant_vc_q;
  logic [VcW-1:0]   rr_ptr_q;
  logic             overflow_q;

  logic [NumVc-1:0] nonempty;
  logic [NumVc-1:0] push_vec;
  logic [NumVc-1:0] pop_vec;
  logic [VcW-1:0]   pick_vc;
  logic [VcW-1:0]   cand_vc;
  logic [VcW-1:0]   sel_vc;
  logic             pick_found;
  logic             handshake;
  logic             drop;

  always_comb begin
    nonempty = '0;
    for (int v = 0; v < NumVc; v++) begin
      nonempty[v] = (count_q[v] != '0);
    end
  end

  // Round-robin search begins one past the last served VC; the served VC
  // itself is visited last.
  always_comb begin
    pick_vc    = '0;
    pick_found = 1'b0;
    cand_vc    = '0;
    for (int i = 1; i <= NumVc; i++) begin
      cand_vc = rr_ptr_q + VcW'(i);
      if (!pick_found && nonempty[cand_vc]) begin
        pick_vc    = cand_vc;
        pick_found = 1'b1;
      end
    end
  end

  // Handshake: a flit transfers on a rising edge where valid & ready. Once
  // valid rises it stays high, and data/virtual_channel_id stay constant,
  // until that transfer happens (the grant locks while ready is low).
  assign sel_vc             = (state_q == StLocked) ? grant_vc_q : pick_vc;
  assign valid              = (state_q == StLocked) || pick_found;
  assign data               = mem[sel_vc][rd_ptr_q[sel_vc]];
  assign virtual_channel_id = sel_vc;
  assign handshake          = valid & ready;
  assign overflow_o         = overflow_q;
  assign dbg_state          = state_q;

  // A full VC still takes a flit when its head leaves in the same cycle.
  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    drop     = 1'b0;
    if (handshake) begin
      pop_vec[sel_vc] = 1'b1;
    end
    if (noc_flit_valid_i) begin
      if ((count_q[noc_virtual_channel_id_i] != CntW'(BufferDepth)) ||
          pop_vec[noc_virtual_channel_id_i]) begin
        push_vec[noc_virtual_channel_id_i] = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_vec[noc_virtual_channel_id_i]) begin
      mem[noc_virtual_channel_id_i][wr_ptr_q[noc_virtual_channel_id_i]] <= noc_flit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NumVc; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      state_q      <= StIdle;
      grant_vc_q   <= '0;
      rr_ptr_q     <= '1;
      noc_credit_o <= '0;
      overflow_q   <= 1'b0;
    end else begin
      for (int v = 0; v < NumVc; v++) begin
        if (push_vec[v]) begin
          wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
        end
        if (pop_vec[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
        end
        count_q[v] <= count_q[v] + CntW'(push_vec[v]) - CntW'(pop_vec[v]);
      end
      noc_credit_o <= pop_vec;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (handshake) begin
        state_q  <= StIdle;
        rr_ptr_q <= sel_vc;
      end else if (valid) begin
        state_q    <= StLocked;
        grant_vc_q <= sel_vc;
      end
    end
  end

endmodule
